// File: rtl/causal_net_sequencer.sv
// Sequences a stack of L causal conv layers: restarts each layer in turn, waits for
// its result, pushes it into the next activation cache and holds the final result.
module causal_net_sequencer #(
  parameter int W = 16,
  parameter int D = 4,
  parameter int L = 4,
  parameter int TIMEOUT = 64,
  parameter logic [L-1:0] RELU_MASK = {L{1'b1}} >> 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [L-1:0]   layer_rst,
  output logic [L-1:0]   layer_apply_relu,
  input  logic [L-1:0]   layer_out_v,
  input  logic [D*W-1:0] layer_out,
  output logic [L-1:0]   cache_push,
  output logic [D*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           error,
  output logic [31:0]    sample_count,
  output logic [2:0]     dbg_state
);

  localparam int KW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(L - 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  localparam logic [L-1:0]  ONE    = L'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_next;
  logic [CW-1:0]   cnt;

  // Handshakes: a sample transfers on in_valid & in_ready (in_ready only in IDLE);
  // a result transfers on out_valid & out_ready, out_data frozen while out_valid is high.
  assign in_ready         = (state == S_IDLE);
  assign layer_apply_relu = RELU_MASK;
  assign dbg_state        = state;
  assign k_next           = k + 1'b1;

  // layer_rst and cache_push are registered on entry to START/PUSH so each is a
  // single-cycle, single-bit pulse aligned with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= '0;
      cnt          <= '0;
      layer_rst    <= '0;
      cache_push   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      error        <= 1'b0;
      sample_count <= '0;
    end else begin
      layer_rst  <= '0;
      cache_push <= '0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            k         <= '0;
            layer_rst <= ONE;
            state     <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (layer_out_v[k]) begin
            cache_push <= ONE << k;
            state      <= S_PUSH;
          end else if (cnt == C_LAST) begin
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PUSH: begin
          if (k == K_LAST) begin
            out_data  <= layer_out;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            k         <= k_next;
            layer_rst <= ONE << k_next;
            state     <= S_START;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            sample_count <= sample_count + 1'b1;
            state        <= S_IDLE;
          end
        end
        S_ERROR: begin
          error <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_causal_net_sequencer.sv
// Randomized bench for causal_net_sequencer: behavioural layer models plus an
// event scoreboard whose timing is derived from the per-layer cycle budget.
`timescale 1ns/1ps
module tb_causal_net_sequencer;

  localparam int W = 16;
  localparam int D = 4;
  localparam int L = 4;
  localparam int TIMEOUT = 64;
  localparam logic [L-1:0] RELU_EXP = 4'b0111;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid, error;
  logic [L-1:0]   layer_rst, layer_apply_relu, cache_push;
  logic [L-1:0]   layer_out_v = '0;
  logic [D*W-1:0] layer_out = '0;
  logic [D*W-1:0] out_data;
  logic [31:0]    sample_count;
  logic [2:0]     dbg_state;

  causal_net_sequencer #(.W(W), .D(D), .L(L), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .layer_rst(layer_rst), .layer_apply_relu(layer_apply_relu),
    .layer_out_v(layer_out_v), .layer_out(layer_out), .cache_push(cache_push),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .error(error), .sample_count(sample_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- layer models ----------------
  // Layer k raises out_v dly[k] cycles after its restart pulse; spur[k] forces it high.
  int unsigned dly [L];
  int unsigned age [L];
  bit          armed [L];
  logic [L-1:0] spur = '0;

  always @(negedge clk) begin
    for (int k = 0; k < L; k++) begin
      if (rst) begin
        armed[k] = 1'b0;
        age[k]   = 0;
      end else if (layer_rst[k]) begin
        armed[k] = 1'b1;
        age[k]   = 0;
      end else if (armed[k]) begin
        age[k]++;
      end
      layer_out_v[k] = !rst && (spur[k] || (armed[k] && age[k] >= dly[k]));
    end
  end

  // ---------------- scoreboard ----------------
  // Event token: {cycle offset from first acceptance, type, index}.
  // Types: 1 layer_rst, 2 cache_push, 3 out_valid rise, 4 acceptance, 5 error rise.
  logic [31:0] exp_q[$];
  logic [63:0] exp_data = '0;
  logic [31:0] exp_count = '0;
  int          cyc = 0;
  int          base = 0;
  bit          base_armed = 1'b0;
  int          acc_count = 0;
  logic        ov_prev = 1'b0;
  logic        err_prev = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] tok(input int off, input int typ, input int idx);
    return {16'(off), 8'(typ), 8'(idx)};
  endfunction

  // Expected events of one sample accepted at offset off; returns the DONE offset or -1.
  function automatic int expect_sample(input int off);
    int t;
    int n;
    t = off + 1;
    exp_q.push_back(tok(off, 4, 0));
    for (int k = 0; k < L; k++) begin
      n = spur[k] ? 1 : ((dly[k] < 1) ? 1 : int'(dly[k]));
      exp_q.push_back(tok(t, 1, k));
      if (n > TIMEOUT) begin
        exp_q.push_back(tok(t + TIMEOUT + 1, 5, 0));
        return -1;
      end
      exp_q.push_back(tok(t + n + 1, 2, k));
      t = t + n + 2;
    end
    exp_q.push_back(tok(t, 3, 0));
    return t;
  endfunction

  task automatic log_evt(input int typ, input int idx);
    logic [31:0] want;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("event", tok(cyc - base, typ, idx), want);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ov_prev  = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (base_armed) begin
          base       = cyc;
          base_armed = 1'b0;
        end
        acc_count++;
        log_evt(4, 0);
      end
      for (int k = 0; k < L; k++) if (layer_rst[k]) log_evt(1, k);
      for (int k = 0; k < L; k++) if (cache_push[k]) log_evt(2, k);
      if (out_valid && !ov_prev) begin
        log_evt(3, 0);
        chk("out_data_capture", out_data, exp_data);
        chk("relu_mask", layer_apply_relu, RELU_EXP);
      end
      if (error && !err_prev) log_evt(5, 0);
      ov_prev  = out_valid;
      err_prev = error;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_layer_rst"}, layer_rst, '0);
    chk({tag, "_cache_push"}, cache_push, '0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_count"}, sample_count, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    exp_q.delete();
    exp_count = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_accept(input bit drop);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_wait", ok, 1'b1);
    @(posedge clk);
    #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic do_sample(input int hold);
    int done_off;
    bit seen;
    layer_out = exp_data;
    done_off = expect_sample(0);
    base_armed = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1;
    wait_accept(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("out_valid_wait", seen, 1'b1);
    if (!seen) return;
    chk("latency", cyc - base, done_off);
    layer_out = {$urandom, $urandom};
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_data", out_data, exp_data);
      @(posedge clk);
      #1;
    end
    if (hold > 0) @(negedge clk);
    out_ready = 1'b1;
    chk("handshake_out_valid", out_valid, 1'b1);
    chk("handshake_out_data", out_data, exp_data);
    chk("handshake_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    exp_count = exp_count + 1;
    chk("after_out_valid", out_valid, 1'b0);
    chk("after_in_ready", in_ready, 1'b1);
    chk("sample_count", sample_count, exp_count);
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int t_done;
    int start_acc;

    for (int k = 0; k < L; k++) dly[k] = 10;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    chk("init_relu", layer_apply_relu, RELU_EXP);
    @(posedge clk);
    #1 rst = 1'b0;

    // all layers answer after 10 cycles: 49-cycle latency
    exp_data = 64'h0123_4567_89AB_CDEF;
    do_sample(0);

    // consumer stalls five cycles
    exp_data = 64'h0001_0002_0003_0004;
    do_sample(5);

    // spurious out_v on another layer and early out_v during START
    dly = '{10, 0, 10, 10};
    spur = 4'b1000;
    exp_data = {$urandom, $urandom};
    do_sample(1);
    spur = '0;

    // randomized delays, stalls and spurious strobes
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < L; k++) dly[k] = $urandom_range(0, 14);
      spur = ($urandom_range(0, 3) == 0) ? L'($urandom_range(0, 15)) : '0;
      exp_data = {$urandom, $urandom};
      do_sample($urandom_range(0, 3));
    end
    spur = '0;

    // back-to-back samples with in_valid and out_ready held high
    for (int k = 0; k < L; k++) dly[k] = $urandom_range(2, 6);
    exp_data = {$urandom, $urandom};
    layer_out = exp_data;
    t_done = expect_sample(0);
    void'(expect_sample(t_done + 1));
    void'(expect_sample(2 * (t_done + 1)));
    start_acc = acc_count;
    base_armed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (acc_count - start_acc >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_accepts", ok, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sample_count == exp_count + 3) break;
    end
    exp_count = exp_count + 3;
    chk("b2b_count", sample_count, exp_count);
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("b2b_exp_q_empty", exp_q.size(), 0);

    // reset during WAIT of layer 1 discards the sample
    for (int k = 0; k < L; k++) dly[k] = 10;
    exp_data = {$urandom, $urandom};
    layer_out = exp_data;
    exp_q.push_back(tok(0, 4, 0));
    exp_q.push_back(tok(1, 1, 0));
    exp_q.push_back(tok(12, 2, 0));
    exp_q.push_back(tok(13, 1, 1));
    base_armed = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1;
    wait_accept(1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc - base >= 18) break;
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort");
    chk("abort_exp_q_empty", exp_q.size(), 0);
    exp_q.delete();
    exp_count = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_data = {$urandom, $urandom};
    do_sample(0);

    // layer 2 never answers: timeout, sticky error until reset
    dly = '{10, 10, 1000, 10};
    void'(expect_sample(0));
    base_armed = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1;
    wait_accept(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (error) begin
        ok = 1'b1;
        break;
      end
    end
    chk("error_wait", ok, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("err_in_ready", in_ready, 1'b0);
      chk("err_out_valid", out_valid, 1'b0);
      chk("err_sticky", error, 1'b1);
      chk("err_layer_rst", layer_rst, '0);
      chk("err_cache_push", cache_push, '0);
    end
    chk("err_exp_q_empty", exp_q.size(), 0);
    in_valid = 1'b0;
    do_reset();

    // recovery after reset
    for (int k = 0; k < L; k++) dly[k] = 10;
    exp_data = {$urandom, $urandom};
    do_sample(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
